seg_memory: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits directly after seg_execute and feeds the WB stage and the forwarding unit.
- Contains the EX/MEM pipeline register, a byte-addressable word data memory, byte/half/word load/store with sign/zero extension, and the branch decision (PCSrc).
- Also provides a read-only debug port so the debug unit can dump data memory.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/seg_memory_ram.sv | 41 ++++
 rtl/seg_memory.sv | 147 ++++++++++++++
 tb/tb_seg_memory.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-bus bit map, access-size encodings and data-memory defaults.
// Revision 1.0
`default_nettype none
package mips_pkg;
  localparam int NB_DADDR_DEF = 8;

  localparam int M_BRANCH   = 8;
  localparam int M_BRANCHNE = 7;
  localparam int M_MEMREAD  = 6;
  localparam int M_MEMWRITE = 5;
  localparam int M_UNSIGNED = 4;
  localparam int M_SIZE_HI  = 3;
  localparam int M_SIZE_LO  = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WRSV = 2'b10,
    SZ_WORD = 2'b11
  } size_e;
endpackage
`default_nettype wire

// File: rtl/seg_memory_ram.sv
// seg_memory_ram: dual-port word RAM, port A byte-enable write / read-first, port B read-only.
// Revision 1.0
`default_nettype none
module seg_memory_ram #(
  parameter int LEN      = 32,
  parameter int NB_DADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_we_a,
  input  logic [NB_DADDR-1:0] i_addr_a,
  input  logic [LEN-1:0]      i_wdata_a,
  output logic [LEN-1:0]      o_rdata_a,
  input  logic [NB_DADDR-1:0] i_addr_b,
  output logic [LEN-1:0]      o_rdata_b
);
  logic [LEN-1:0] mem_q [2**NB_DADDR];
  logic [LEN-1:0] rdata_a_q;
  logic [LEN-1:0] rdata_b_q;

  // Contents are never reset; only the read registers are.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we_a[i]) mem_q[i_addr_a][8*i +: 8] <= i_wdata_a[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem_q[i_addr_a];
      rdata_b_q <= mem_q[i_addr_b];
    end
  end

  assign o_rdata_a = rdata_a_q;
  assign o_rdata_b = rdata_b_q;
endmodule
`default_nettype wire

// File: rtl/seg_memory.sv
// seg_memory: MIPS MEM stage - EX/MEM register, byte-addressable data memory, branch decision.
// Revision 1.0
`default_nettype none
module seg_memory
  import mips_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 9,
  parameter int NB_DADDR   = NB_DADDR_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LEN-1:0]        i_PC_branch,
  input  logic [LEN-1:0]        i_ALU_result,
  input  logic                  i_ALU_zero,
  input  logic [LEN-1:0]        i_write_data,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_DADDR-1:0]   i_dbg_addr,
  output logic [LEN-1:0]        o_read_data,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [LEN-1:0]        o_PC_branch,
  output logic                  o_PC_src,
  output logic                  o_misaligned,
  output logic [LEN-1:0]        o_dbg_data
);
  logic          branch, branch_ne, mem_read, mem_write, is_unsigned;
  logic [1:0]    size, offset;
  logic          is_byte, is_half, misaligned;
  logic [3:0]    be;
  logic [LEN-1:0] wdata_lanes;
  logic [NB_DADDR-1:0] word_idx;

  logic [LEN-1:0]        alu_q, pcb_q;
  logic [NB_ADDR-1:0]    wreg_q;
  logic [NB_CTRL_WB-1:0] wb_q;
  logic                  pcsrc_q, mis_q, rd_en_q, uns_q;
  logic [1:0]            off_q, size_q;
  logic                  pcsrc_d, mis_d, rd_en_d;

  logic [LEN-1:0] ram_rdata, lane_data;

  assign branch      = i_ctrl_mem_bus[M_BRANCH];
  assign branch_ne   = i_ctrl_mem_bus[M_BRANCHNE];
  assign mem_read    = i_ctrl_mem_bus[M_MEMREAD];
  assign mem_write   = i_ctrl_mem_bus[M_MEMWRITE];
  assign is_unsigned = i_ctrl_mem_bus[M_UNSIGNED];
  assign size        = i_ctrl_mem_bus[M_SIZE_HI:M_SIZE_LO];
  assign offset      = i_ALU_result[1:0];
  assign word_idx    = i_ALU_result[NB_DADDR+1:2];
  assign is_byte     = (size == SZ_BYTE);
  assign is_half     = (size == SZ_HALF);

  // Sizes 10 and 11 both behave as a word access.
  always_comb begin
    misaligned  = 1'b0;
    be          = 4'b1111;
    wdata_lanes = i_write_data;
    if (is_byte) begin
      be          = 4'b0001 << offset;
      wdata_lanes = {4{i_write_data[7:0]}};
    end else if (is_half) begin
      misaligned  = offset[0];
      be          = 4'b0011 << offset;
      wdata_lanes = {2{i_write_data[15:0]}};
    end else begin
      misaligned  = (offset != 2'b00);
    end
  end

  assign pcsrc_d = (branch & i_ALU_zero) | (branch_ne & ~i_ALU_zero);
  assign mis_d   = (mem_read | mem_write) & misaligned;
  assign rd_en_d = mem_read & ~misaligned;

  seg_memory_ram #(
    .LEN      (LEN),
    .NB_DADDR (NB_DADDR)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we_a    (be & {4{mem_write & ~misaligned & i_rst}}),
    .i_addr_a  (word_idx),
    .i_wdata_a (wdata_lanes),
    .o_rdata_a (ram_rdata),
    .i_addr_b  (i_dbg_addr),
    .o_rdata_b (o_dbg_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      alu_q   <= '0;
      pcb_q   <= '0;
      wreg_q  <= '0;
      wb_q    <= '0;
      pcsrc_q <= 1'b0;
      mis_q   <= 1'b0;
      rd_en_q <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      alu_q   <= i_ALU_result;
      pcb_q   <= i_PC_branch;
      wreg_q  <= i_write_register;
      wb_q    <= i_ctrl_wb_bus;
      pcsrc_q <= pcsrc_d;
      mis_q   <= mis_d;
      rd_en_q <= rd_en_d;
      uns_q   <= is_unsigned;
      off_q   <= offset;
      size_q  <= size;
    end
  end

  // Lane extraction works on the word registered by the RAM and the latched offset.
  assign lane_data = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    o_read_data = '0;
    if (rd_en_q) begin
      if (size_q == SZ_BYTE)
        o_read_data = uns_q ? {{(LEN-8){1'b0}}, lane_data[7:0]}
                            : {{(LEN-8){lane_data[7]}}, lane_data[7:0]};
      else if (size_q == SZ_HALF)
        o_read_data = uns_q ? {{(LEN-16){1'b0}}, lane_data[15:0]}
                            : {{(LEN-16){lane_data[15]}}, lane_data[15:0]};
      else
        o_read_data = ram_rdata;
    end
  end

  assign o_ALU_result     = alu_q;
  assign o_PC_branch      = pcb_q;
  assign o_write_register = wreg_q;
  assign o_ctrl_wb_bus    = wb_q;
  assign o_PC_src         = pcsrc_q;
  assign o_misaligned     = mis_q;

  logic unused_ok;
  assign unused_ok = ^{i_ALU_result[LEN-1:NB_DADDR+2], i_ctrl_mem_bus[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_seg_memory.sv
// tb_seg_memory: directed table-driven check of the MEM stage.
// Revision 1.0
`default_nettype none
module tb_seg_memory;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_PC_branch, i_ALU_result, i_write_data;
  logic        i_ALU_zero;
  logic [4:0]  i_write_register;
  logic [1:0]  i_ctrl_wb_bus;
  logic [8:0]  i_ctrl_mem_bus;
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_read_data, o_ALU_result, o_PC_branch, o_dbg_data;
  logic [4:0]  o_write_register;
  logic [1:0]  o_ctrl_wb_bus;
  logic        o_PC_src, o_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] NOP = 9'h000, BEQ = 9'h100, BNE = 9'h080;
  localparam logic [8:0] SW = 9'h02C, SH = 9'h024, SB = 9'h020;
  localparam logic [8:0] LW = 9'h04C, LH = 9'h044, LHU = 9'h054;
  localparam logic [8:0] LB = 9'h040, LBU = 9'h050, LWSW = 9'h06C;

  always #5 i_clk = ~i_clk;

  seg_memory dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_PC_branch(i_PC_branch), .i_ALU_result(i_ALU_result),
    .i_ALU_zero(i_ALU_zero), .i_write_data(i_write_data), .i_write_register(i_write_register),
    .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus), .i_dbg_addr(i_dbg_addr),
    .o_read_data(o_read_data), .o_ALU_result(o_ALU_result), .o_write_register(o_write_register),
    .o_ctrl_wb_bus(o_ctrl_wb_bus), .o_PC_branch(o_PC_branch), .o_PC_src(o_PC_src),
    .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
  );

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] data;
    logic        zero;
    logic [31:0] pcb;
    logic [7:0]  dbg;
    logic        dbg_chk;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_src;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [8:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                     input logic zero, input logic [31:0] pcb, input logic [31:0] exp_rd,
                     input logic exp_mis, input logic exp_src, input logic dbg_chk,
                     input logic [7:0] dbg, input logic [31:0] exp_dbg);
    vec_t v;
    v.ctrl = ctrl; v.addr = addr; v.data = data; v.zero = zero; v.pcb = pcb;
    v.dbg = dbg; v.dbg_chk = dbg_chk; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    v.exp_src = exp_src; v.exp_dbg = exp_dbg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                       input logic zero, input logic [31:0] pcb, input logic [7:0] dbg,
                       input logic [4:0] wreg, input logic [1:0] wb);
    i_ctrl_mem_bus = ctrl; i_ALU_result = addr; i_write_data = data; i_ALU_zero = zero;
    i_PC_branch = pcb; i_dbg_addr = dbg; i_write_register = wreg; i_ctrl_wb_bus = wb;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " read_data"}, o_read_data, 32'h0);
    check({tag, " ALU_result"}, o_ALU_result, 32'h0);
    check({tag, " PC_branch"}, o_PC_branch, 32'h0);
    check({tag, " wreg/wb"}, {25'h0, o_write_register, o_ctrl_wb_bus}, 32'h0);
    check({tag, " PC_src/mis"}, {30'h0, o_PC_src, o_misaligned}, 32'h0);
    check({tag, " dbg_data"}, o_dbg_data, 32'h0);
  endtask

  initial begin
    i_rst = 1'b0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0, 8'd0, 5'd0, 2'd0);
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0, 8'd0, 5'd0, 2'd0);
    check_all_zero("reset0");

    // Known word at 0x10, then a reset cycle carrying a store that must be dropped.
    i_rst = 1'b1;
    drive(SW, 32'h10, 32'h12345678, 1'b1, 32'h44, 8'd4, 5'd7, 2'd3);
    check("pre-reset ALU_result", o_ALU_result, 32'h10);
    i_rst = 1'b0;
    drive(SW, 32'h10, 32'hDEADBEEF, 1'b1, 32'h44, 8'd4, 5'd7, 2'd3);
    check_all_zero("reset1");
    i_rst = 1'b1;
    drive(LW, 32'h10, 32'h0, 1'b0, 32'h0, 8'd4, 5'd0, 2'd0);
    check("reset store dropped", o_read_data, 32'h12345678);
    check("dbg after reset", o_dbg_data, 32'h12345678);

    //  ctrl  addr       data         z     pcb     exp_rd        mis   src   dchk  dbg  exp_dbg
    add(SW,   32'h08,   32'h11223344, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h08,   32'h0,        1'b0, 32'h0,  32'h11223344, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(SW,   32'h20,   32'h80FF7F01, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LB,   32'h23,   32'h0,        1'b0, 32'h0,  32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LBU,  32'h23,   32'h0,        1'b0, 32'h0,  32'h00000080, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LB,   32'h21,   32'h0,        1'b0, 32'h0,  32'h0000007F, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LH,   32'h22,   32'h0,        1'b0, 32'h0,  32'hFFFF80FF, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LHU,  32'h20,   32'h0,        1'b0, 32'h0,  32'h00007F01, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(SB,   32'h21,   32'h123456AA, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h20,   32'h0,        1'b0, 32'h0,  32'h80FFAA01, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(NOP,  32'h0,    32'h0,        1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 8'd8, 32'h80FFAA01);
    add(SW,   32'h04,   32'hCAFEF00D, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(SW,   32'h06,   32'hFFFFFFFF, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h04,   32'h0,        1'b0, 32'h0,  32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 8'd1, 32'hCAFEF00D);
    add(LH,   32'h21,   32'h0,        1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h22,   32'h0,        1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
    add(SH,   32'h06,   32'h7777BEEF, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h04,   32'h0,        1'b0, 32'h0,  32'hBEEFF00D, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(BEQ,  32'h0,    32'h0,        1'b1, 32'h40, 32'h0,        1'b0, 1'b1, 1'b0, 8'd0, 32'h0);
    add(BNE,  32'h0,    32'h0,        1'b1, 32'h48, 32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(BNE,  32'h5,    32'h0,        1'b0, 32'h4C, 32'h0,        1'b0, 1'b1, 1'b0, 8'd0, 32'h0);
    add(BEQ,  32'h5,    32'h0,        1'b0, 32'h50, 32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(BEQ|BNE, 32'h5, 32'h0,        1'b0, 32'h54, 32'h0,        1'b0, 1'b1, 1'b0, 8'd0, 32'h0);
    add(SW,   32'h400,  32'h5A5A5A5A, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h000,  32'h0,        1'b0, 32'h0,  32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LWSW, 32'h000,  32'h01020304, 1'b0, 32'h0,  32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    add(LW,   32'h000,  32'h0,        1'b0, 32'h0,  32'h01020304, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);

    foreach (vecs[k]) begin
      logic [4:0] wreg;
      logic [1:0] wb;
      wreg = 5'(k + 3);
      wb   = 2'(k);
      drive(vecs[k].ctrl, vecs[k].addr, vecs[k].data, vecs[k].zero, vecs[k].pcb,
            vecs[k].dbg, wreg, wb);
      check($sformatf("v%0d read_data", k), o_read_data, vecs[k].exp_rd);
      check($sformatf("v%0d misaligned", k), {31'h0, o_misaligned}, {31'h0, vecs[k].exp_mis});
      check($sformatf("v%0d PC_src", k), {31'h0, o_PC_src}, {31'h0, vecs[k].exp_src});
      check($sformatf("v%0d PC_branch", k), o_PC_branch, vecs[k].pcb);
      check($sformatf("v%0d ALU_result", k), o_ALU_result, vecs[k].addr);
      check($sformatf("v%0d wreg/wb", k), {25'h0, o_write_register, o_ctrl_wb_bus},
            {25'h0, wreg, wb});
      if (vecs[k].dbg_chk)
        check($sformatf("v%0d dbg_data", k), o_dbg_data, vecs[k].exp_dbg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
